// File: rtl/fpu_iter_sequencer.sv
// fpu_iter_sequencer: control FSM for the iterative divide/sqrt mantissa
// datapath. It accepts one operation per valid/ready handshake, drives the
// load/step/norm strobes, and runs the shared iteration counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous abort of any in-flight operation
//   in_valid/in_ready request handshake, in_op selects divide/sqrt
//   dp_load/step/norm datapath strobes, dp_op is the latched op
//   cnt_sync_rst/en   iteration counter control, cnt_value is read back
//   out_valid/ready   result handshake, out_err qualifies out_valid
//   busy              sequencer is not idle
module fpu_iter_sequencer #(
  parameter int CNT_W      = 8,
  parameter int DIV_ITERS  = 27,
  parameter int SQRT_ITERS = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_norm,
  output logic [1:0]       dp_op,
  output logic             cnt_sync_rst,
  output logic             cnt_en,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic             busy
);

  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  if (DIV_ITERS < 1 || DIV_ITERS > CNT_MAX ||
      SQRT_ITERS < 1 || SQRT_ITERS > CNT_MAX) begin : g_bad_iters
    $error("fpu_iter_sequencer: ITERS out of counter range");
  end

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
  localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(SQRT_ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_NORM,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       op;
  logic             err;
  logic [CNT_W-1:0] last;

  // Only divide/sqrt ever reach ITER, so op[0] picks the step count.
  assign last = op[0] ? SQRT_LAST : DIV_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op    <= 2'b00;
      err   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            op <= in_op;
            // Reserved ops skip the datapath and report an error.
            if (in_op[1]) begin
              state <= S_DONE;
              err   <= 1'b1;
            end else begin
              state <= S_LOAD;
              err   <= 1'b0;
            end
          end
        end
        S_LOAD: state <= S_ITER;
        S_ITER: begin
          if (cnt_value == last) begin
            state <= S_NORM;
          end else if (cnt_value > last) begin
            // Counter ran past the final step: abandon the result.
            state <= S_DONE;
            err   <= 1'b1;
          end
        end
        S_NORM: state <= S_DONE;
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flush masks every strobe in the same cycle it is raised.
  assign in_ready     = (state == S_IDLE) & ~flush;
  assign busy         = (state != S_IDLE);
  assign dp_load      = (state == S_LOAD) & ~flush;
  assign dp_step      = (state == S_ITER) & ~flush;
  assign dp_norm      = (state == S_NORM) & ~flush;
  assign dp_op        = op;
  // Held in IDLE/LOAD so the counter reads 0 in the first ITER cycle.
  assign cnt_sync_rst = (state == S_IDLE) | (state == S_LOAD);
  assign cnt_en       = dp_step;
  assign out_valid    = (state == S_DONE) & ~flush;
  assign out_err      = out_valid & err;

endmodule

// File: tb/tb_fpu_iter_sequencer.sv
// tb_fpu_iter_sequencer: checks fpu_iter_sequencer against a per-cycle
// timeline derived from the operation, backpressure and abort points.
module tb_fpu_iter_sequencer;

  localparam int CNT_W      = 8;
  localparam int DIV_ITERS  = 27;
  localparam int SQRT_ITERS = 26;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic             dp_load;
  logic             dp_step;
  logic             dp_norm;
  logic [1:0]       dp_op;
  logic             cnt_sync_rst;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_value;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_err;
  logic             busy;

  logic             cnt_force = 1'b0;
  logic [CNT_W-1:0] cnt_q = '0;

  int errs   = 0;
  int checks = 0;

  fpu_iter_sequencer #(
    .CNT_W     (CNT_W),
    .DIV_ITERS (DIV_ITERS),
    .SQRT_ITERS(SQRT_ITERS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .dp_load     (dp_load),
    .dp_step     (dp_step),
    .dp_norm     (dp_norm),
    .dp_op       (dp_op),
    .cnt_sync_rst(cnt_sync_rst),
    .cnt_en      (cnt_en),
    .cnt_value   (cnt_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_err     (out_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Shared iteration counter, with an override to inject a fault.
  always @(posedge clk) begin
    if (cnt_sync_rst) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_value = cnt_force ? 8'd40 : cnt_q;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [8:0] sigs();
    return {in_ready, busy, dp_load, dp_step, dp_norm,
            cnt_sync_rst, cnt_en, out_valid, out_err};
  endfunction

  localparam logic [8:0] IDLE_SIGS = 9'b100001000;

  function automatic int done_cycle(input logic [1:0] op, input int ft);
    if (op[1]) return 1;
    if (ft > 0) return ft + 1;
    return (op == 2'b00 ? DIV_ITERS : SQRT_ITERS) + 3;
  endfunction

  // One operation; fl/rs/ft are the cycle (after acceptance) of a flush,
  // a reset, or a forced counter fault, 0 meaning none.
  task automatic run_op(input logic [1:0] op, input int bp,
                        input int fl, input int rs, input int ft);
    int n, d, stop, last_st;
    bit res, err, f, live;
    logic [8:0] e;
    res = op[1];
    n = res ? 0 : (op == 2'b00 ? DIV_ITERS : SQRT_ITERS);
    d = done_cycle(op, ft);
    last_st = (ft > 0) ? ft : n + 1;
    err = res || (ft > 0);
    stop = (fl > 0) ? fl : (rs > 0) ? rs : d + bp;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    cnt_force = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    out_ready = 1'($urandom_range(0, 1));
    #1 chk("accept_rdy", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k <= stop + 2; k++) begin
      @(negedge clk);
      live = (k <= stop);
      f = (k == fl);
      flush = f;
      rst = (rs > 0) && (k == rs || k == rs + 1);
      cnt_force = (k == ft);
      out_ready = (k >= d + bp);
      if (rst) in_valid = 1'b1;
      else if (live) in_valid = 1'($urandom_range(0, 1));
      else in_valid = 1'b0;
      in_op = 2'($urandom);
      #1;
      if (live) begin
        e[8] = 1'b0;
        e[7] = 1'b1;
        e[6] = !res && k == 1 && !f;
        e[5] = !res && k >= 2 && k <= last_st && !f;
        e[4] = !res && ft == 0 && k == n + 2 && !f;
        e[3] = !res && k == 1;
        e[2] = e[5];
        e[1] = k >= d && !f;
        e[0] = e[1] && err;
        chk("sig", {23'd0, sigs()}, {23'd0, e});
        chk("dp_op", {30'd0, dp_op}, {30'd0, op});
        if (!res && k >= 2 && k <= last_st && k != ft)
          chk("cnt", {24'd0, cnt_value}, k - 2);
      end else begin
        chk("idle_sig", {23'd0, sigs()}, {23'd0, IDLE_SIGS});
        if (rs > 0) chk("rst_op", {30'd0, dp_op}, 32'd0);
      end
    end
    rst = 1'b0;
    flush = 1'b0;
    cnt_force = 1'b0;
  endtask

  initial begin
    logic [1:0] op;
    int bp, r, d, fl, rs, ft;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_sig", {23'd0, sigs()}, {23'd0, IDLE_SIGS});
    chk("reset_op", {30'd0, dp_op}, 32'd0);

    run_op(2'b00, 0, 0, 0, 0);
    run_op(2'b01, 5, 0, 0, 0);
    run_op(2'b10, 0, 0, 0, 0);
    run_op(2'b11, 2, 0, 0, 0);
    run_op(2'b00, 0, 12, 0, 0);
    run_op(2'b00, 0, 0, 0, 0);
    run_op(2'b00, 3, 0, 31, 0);
    run_op(2'b01, 0, 10, 10, 0);
    run_op(2'b01, 0, 0, 0, 15);
    run_op(2'b01, 1, 0, 0, 27);
    run_op(2'b00, 2, 32, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      bp = $urandom_range(0, 4);
      r = $urandom_range(0, 7);
      fl = 0;
      rs = 0;
      ft = 0;
      d = done_cycle(op, 0);
      if (r == 0) fl = $urandom_range(1, d + bp);
      else if (r == 1) rs = $urandom_range(1, d + bp);
      else if (r == 2 && !op[1]) ft = $urandom_range(2, d - 2);
      run_op(op, bp, fl, rs, ft);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
